pwm_ramp_sched: RTL and testbench
=================================

# pwm_ramp_sched

Multi-channel PWM controller that owns the shared period counter, per-channel duty compare, and a ramp scheduler for the PWM IP. Software-side logic (the AXI4-Lite register slave) writes per-channel target duty and step size. This block moves each channel's duty toward its target by one step per PWM period, and applies new duties only at period boundaries, so outputs never glitch. A single time-multiplexed ramp ALU is shared round-robin across all channels.

## Interface
- NUM_CH, 4, number of PWM channels (1..16)
- CNT_W, 16, counter/duty/step width

- ACLK  in  1  clock
- ARESETN  in  1  reset, asynchronous, active-low
- enable  in  1  global run; 0 holds counter and forces outputs low
- period  in  CNT_W  terminal count; PWM period = period+1 cycles
- cfg_we  in  1  one-cycle write strobe for target/step
- cfg_ch  in  $clog2(NUM_CH)  channel addressed by cfg_we; values ≥NUM_CH ignored
- cfg_target  in  CNT_W  target duty (high cycles per period)
- cfg_step  in  CNT_W  per-period increment; 0 = jump straight to target
- pwm_out  out  NUM_CH  PWM outputs, registered
- period_tick  out  1  one-cycle pulse in first cycle of each period
- busy  out  NUM_CH  bit i = channel i shadow duty ≠ target
- sweep_active  out  1  ramp FSM not IDLE

## Operation
- Per channel: target, step (config regs), shadow duty (ramp result), active duty (used by compare).
- Counter cnt: increments while enable=1; wraps to 0 on the edge where cnt ≥ period. The ≥ handles period lowered below the current cnt: wrap on the next edge.
- Wrap edge:
  - active[i] ← shadow[i] for all i
  - period_tick pulses
  - sweep request raised
- pwm_out[i] = 1 when cnt < active[i].
  - active=0: always low.
  - active > period: always high.
- Ramp FSM states: IDLE, SWEEP.
  - IDLE → SWEEP on sweep request, with idx=0.
  - SWEEP processes channel idx each cycle and increments idx.
  - After idx=NUM_CH-1, go to IDLE, or restart SWEEP at idx=0 if pending is set.
- Step rule for channel idx (ALU, CNT_W+1-bit intermediate, no wrap):
  - shadow<target: shadow ← min(shadow+step, target)
  - shadow>target: shadow ← max(shadow−step, target); subtraction saturates at target
  - step=0: shadow ← target
  - equal: unchanged
- Wrap edge during SWEEP: active loads normally; pending ← 1 (at most one pending; further ticks coalesce).
- cfg_we: target/step of cfg_ch written on that edge.
  - If the ALU processes the same channel in the same cycle, it uses the pre-write values.
  - The new values are used at the next sweep.
- enable=0:
  - cnt ← 0, pwm_out ← 0, period_tick ← 0
  - FSM ← IDLE, pending ← 0
  - config/shadow/active retained
  - cfg_we still accepted
- enable 0→1: counting restarts at 0. No tick is generated for that first period; the first tick comes at the first wrap.

## Timing
- Reset (ARESETN low, asynchronous): cnt, all duty/target/step regs, pwm_out, period_tick, busy, sweep_active, pending, idx = 0; FSM = IDLE. Release is synchronised externally to ACLK.
- pwm_out and period_tick are registered from next-state values. In the cycle cnt=0, period_tick=1 and pwm_out already reflects the new active duty.
- Sweep latency: NUM_CH cycles starting the cycle after the wrap edge. The shadow of channel i updates at wrap+1+i.
- Config-to-output latency: a write lands in shadow at the next sweep and reaches pwm_out one period later, so 1–2 periods.
- busy updates the cycle after the shadow or target change.
- A ramp from d0 to d1 with step s settles in ceil(|d1−d0|/s) periods.

## Structure
- Package pwm_ramp_pkg:
  - state enum (IDLE, SWEEP)
  - CNT_W default localparam
  - channel-index typedef
  - saturating add/sub function prototypes
- Sub-module pwm_ramp_alu: combinational single-channel step (shadow, target, step → next shadow). Instantiated once and muxed by idx.
- Top holds counter, register arrays, FSM, compare/output registers.

## Test plan
- Reset mid-run: assert ARESETN low at cnt=5 with ch0 active=3 → pwm_out, period_tick, busy, cnt all 0 immediately (asynchronous); after release, active=0.
- Ramp up: period=9, ch0 target=5 step=2 → high cycles in successive periods 0,2,4,5,5; busy[0] clears after the third sweep.
- Ramp down and jump: ch1 at 8, write target=1 step=3 → 8,5,2,1. Then target=7 step=0 → next period 1, following period 7.
- Extremes: period=9, active=0 → pwm_out constant low; active=12 → constant high; period_tick exactly every 10 cycles.
- Short period: NUM_CH=4, period=1 → ticks every 2 cycles during a 4-cycle sweep. pending coalesces, sweeps run back-to-back, no channel skipped, shadows match the ALU model.
- Config collision and enable: cfg_we to ch2 in the same cycle the sweep processes ch2 → old target used this sweep, new target next. Then enable=0 → cnt=0, outputs low, sweep_active=0; enable=1 → first tick after period+1 cycles.

Source files
------------

// File: rtl/pwm_ramp_pkg.sv
// Shared types and saturating helpers for the PWM ramp scheduler.
// The helpers work on a fixed 32-bit word; callers zero-extend their operands.
package pwm_ramp_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam int CNT_W_DEF = 16;
  localparam int MAX_CH    = 16;
  localparam int SAT_W     = 32;

  typedef logic [3:0]       ch_idx_t;
  typedef logic [SAT_W-1:0] sat_word_t;

  // a + b, clamped so the result never passes lim
  function automatic sat_word_t sat_add_min(input sat_word_t a, input sat_word_t b,
                                            input sat_word_t lim);
    logic [SAT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, lim}) ? lim : sum[SAT_W-1:0];
  endfunction

  // a - b, clamped at lim; only meaningful when a > lim
  function automatic sat_word_t sat_sub_max(input sat_word_t a, input sat_word_t b,
                                            input sat_word_t lim);
    return (b >= (a - lim)) ? lim : (a - b);
  endfunction

endpackage

// File: rtl/pwm_ramp_sched_if.sv
// Configuration write port from the register slave into the ramp scheduler.
interface pwm_ramp_sched_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_target;
  logic [CNT_W-1:0]  cfg_step;

  modport master (output cfg_we, cfg_ch, cfg_target, cfg_step);
  modport slave  (input  cfg_we, cfg_ch, cfg_target, cfg_step);
endinterface

// File: rtl/pwm_ramp_alu.sv
// One ramp step for a single channel: move shadow toward target by step,
// never overshooting; step of zero jumps straight to the target.
module pwm_ramp_alu
  import pwm_ramp_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic [CNT_W-1:0] shadow,
  input  logic [CNT_W-1:0] target,
  input  logic [CNT_W-1:0] step,
  output logic [CNT_W-1:0] shadow_next
);

  sat_word_t s_w, t_w, st_w, r_w;

  always_comb begin
    s_w  = sat_word_t'(shadow);
    t_w  = sat_word_t'(target);
    st_w = sat_word_t'(step);
    r_w  = s_w;
    if (st_w == '0) begin
      r_w = t_w;
    end else if (s_w < t_w) begin
      r_w = sat_add_min(s_w, st_w, t_w);
    end else if (s_w > t_w) begin
      r_w = sat_sub_max(s_w, st_w, t_w);
    end
    shadow_next = CNT_W'(r_w);
  end

endmodule

// File: rtl/pwm_ramp_sched.sv
// Multi-channel PWM: shared period counter, per-channel compare, and a
// round-robin ramp FSM that updates one channel shadow duty per cycle.
module pwm_ramp_sched
  import pwm_ramp_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              enable,
  input  logic [CNT_W-1:0]  period,
  pwm_ramp_sched_if.slave   cfg,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick,
  output logic [NUM_CH-1:0] busy,
  output logic              sweep_active
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [CNT_W-1:0]  target_reg [NUM_CH];
  logic [CNT_W-1:0]  step_reg   [NUM_CH];
  logic [CNT_W-1:0]  shadow_reg [NUM_CH];
  logic [CNT_W-1:0]  active_reg [NUM_CH];
  logic [CNT_W-1:0]  active_next[NUM_CH];
  logic [NUM_CH-1:0] pwm_next;
  logic              wrap;
  logic              last_ch;
  state_t            state_reg;
  logic              pending_reg;
  logic [CH_W-1:0]   idx_reg;
  logic [CNT_W-1:0]  alu_next;

  // >= so that lowering period below the running count wraps on the next edge
  assign wrap     = enable && (cnt_reg >= period);
  assign cnt_next = (enable && !wrap) ? cnt_reg + 1'b1 : '0;
  assign last_ch  = (32'(idx_reg) == NUM_CH - 1);

  // Outputs are registered from next-state values so the first cycle of a
  // period already shows the freshly loaded active duty.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign active_next[gi] = wrap ? shadow_reg[gi] : active_reg[gi];
    assign pwm_next[gi]    = enable && (cnt_next < active_next[gi]);
  end

  pwm_ramp_alu #(.CNT_W(CNT_W)) u_alu (
    .shadow      (shadow_reg[idx_reg]),
    .target      (target_reg[idx_reg]),
    .step        (step_reg[idx_reg]),
    .shadow_next (alu_next)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt_reg     <= '0;
      period_tick <= 1'b0;
      pwm_out     <= '0;
      busy        <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        active_reg[i] <= '0;
        target_reg[i] <= '0;
        step_reg[i]   <= '0;
      end
    end else begin
      cnt_reg     <= cnt_next;
      period_tick <= wrap;
      pwm_out     <= pwm_next;
      for (int i = 0; i < NUM_CH; i++) begin
        active_reg[i] <= active_next[i];
        busy[i]       <= (shadow_reg[i] != target_reg[i]);
        if (cfg.cfg_we && (cfg.cfg_ch == CH_W'(i))) begin
          target_reg[i] <= cfg.cfg_target;
          step_reg[i]   <= cfg.cfg_step;
        end
      end
    end
  end

  // Ramp FSM: a wrap during a sweep is remembered once and replayed right after.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg   <= IDLE;
      pending_reg <= 1'b0;
      idx_reg     <= '0;
      for (int i = 0; i < NUM_CH; i++) shadow_reg[i] <= '0;
    end else if (!enable) begin
      state_reg   <= IDLE;
      pending_reg <= 1'b0;
      idx_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (wrap) begin
            state_reg <= SWEEP;
            idx_reg   <= '0;
          end
        end
        SWEEP: begin
          shadow_reg[idx_reg] <= alu_next;
          if (last_ch) begin
            idx_reg <= '0;
            if (pending_reg || wrap) pending_reg <= 1'b0;
            else                     state_reg   <= IDLE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
            if (wrap) pending_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign sweep_active = (state_reg == SWEEP);

endmodule

// File: tb/tb_pwm_ramp_sched.sv
// Bench for pwm_ramp_sched: queue-based reference model checked every cycle,
// directed ramp/collision/enable/reset scenarios, then randomized traffic.
module tb_pwm_ramp_sched;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [CNT_W-1:0]  per;
  logic [NUM_CH-1:0] pwm_out, busy;
  logic              period_tick, sweep_active;

  pwm_ramp_sched_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_bus ();

  pwm_ramp_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .ACLK         (clk),
    .ARESETN      (rst_n),
    .enable       (en),
    .period       (per),
    .cfg          (cfg_bus),
    .pwm_out      (pwm_out),
    .period_tick  (period_tick),
    .busy         (busy),
    .sweep_active (sweep_active)
  );

  always #5 clk = ~clk;

  // reference model state
  int mcnt;
  int mtarget[NUM_CH], mstep[NUM_CH], mshadow[NUM_CH], mactive[NUM_CH];
  int work_q[$];
  bit mpend;
  logic [NUM_CH-1:0] exp_pwm, exp_busy;
  bit exp_tick, exp_sweep;

  // per-period statistics derived from the model
  int acc[NUM_CH];
  int hist0[$], hist1[$], hist2[$], hist3[$], plen[$];
  int pcycles, tick_cnt;
  bit rec;

  int n_total = 0, n_pass = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
  endtask

  function automatic int step_rule(input int s, input int t, input int st);
    if (st == 0) return t;
    if (s < t)   return (s + st > t) ? t : s + st;
    if (s > t)   return (s - t <= st) ? t : s - st;
    return s;
  endfunction

  task automatic model_reset();
    mcnt = 0; mpend = 0; work_q.delete();
    for (int i = 0; i < NUM_CH; i++) begin
      mtarget[i] = 0; mstep[i] = 0; mshadow[i] = 0; mactive[i] = 0;
    end
    exp_pwm = '0; exp_busy = '0; exp_tick = 0; exp_sweep = 0;
  endtask

  // One clock edge of the specified behaviour, using pre-edge values.
  task automatic model_step();
    bit wrap, was_active;
    int ch;
    wrap = en && (mcnt >= int'(per));
    for (int i = 0; i < NUM_CH; i++) exp_busy[i] = (mshadow[i] != mtarget[i]);
    if (wrap) for (int i = 0; i < NUM_CH; i++) mactive[i] = mshadow[i];
    if (!en) begin
      work_q.delete();
      mpend = 0;
    end else begin
      was_active = (work_q.size() > 0);
      if (was_active) begin
        ch = work_q.pop_front();
        mshadow[ch] = step_rule(mshadow[ch], mtarget[ch], mstep[ch]);
      end
      if (wrap) begin
        if (was_active) mpend = 1;
        else for (int i = 0; i < NUM_CH; i++) work_q.push_back(i);
      end
      if (was_active && work_q.size() == 0 && mpend) begin
        for (int i = 0; i < NUM_CH; i++) work_q.push_back(i);
        mpend = 0;
      end
    end
    if (cfg_bus.cfg_we && int'(cfg_bus.cfg_ch) < NUM_CH) begin
      mtarget[cfg_bus.cfg_ch] = int'(cfg_bus.cfg_target);
      mstep[cfg_bus.cfg_ch]   = int'(cfg_bus.cfg_step);
    end
    mcnt = (en && !wrap) ? mcnt + 1 : 0;
    exp_tick = wrap;
    for (int i = 0; i < NUM_CH; i++) exp_pwm[i] = en && (mcnt < mactive[i]);
    exp_sweep = (work_q.size() > 0);
  endtask

  task automatic compare_all();
    check("pwm_out", pwm_out, exp_pwm);
    check("period_tick", period_tick, exp_tick);
    check("busy", busy, exp_busy);
    check("sweep_active", sweep_active, exp_sweep);
    check("cnt", dut.cnt_reg, mcnt);
    for (int i = 0; i < NUM_CH; i++)
      check($sformatf("shadow%0d", i), dut.shadow_reg[i], mshadow[i]);
  endtask

  task automatic record();
    if (exp_tick) begin
      if (rec) begin
        hist0.push_back(acc[0]); hist1.push_back(acc[1]);
        hist2.push_back(acc[2]); hist3.push_back(acc[3]);
        plen.push_back(pcycles);
      end
      for (int i = 0; i < NUM_CH; i++) acc[i] = 0;
      pcycles = 0;
      rec = 1;
      tick_cnt++;
    end
    pcycles++;
    for (int i = 0; i < NUM_CH; i++) acc[i] += int'(exp_pwm[i]);
  endtask

  task automatic clear_hist();
    hist0.delete(); hist1.delete(); hist2.delete(); hist3.delete(); plen.delete();
    for (int i = 0; i < NUM_CH; i++) acc[i] = 0;
    pcycles = 0; rec = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    record();
  endtask

  task automatic wait_ticks(input int n);
    int start, guard;
    start = tick_cnt; guard = 0;
    while (tick_cnt - start < n && guard < 500) begin
      cycle();
      guard++;
    end
    if (tick_cnt - start < n) begin
      n_total++;
      $display("FAIL wait_ticks timeout actual=%0d required=%0d", tick_cnt - start, n);
    end
  endtask

  task automatic cfg_write(input int ch, input int tgt, input int st);
    cfg_bus.cfg_we     = 1'b1;
    cfg_bus.cfg_ch     = 2'(ch);
    cfg_bus.cfg_target = CNT_W'(tgt);
    cfg_bus.cfg_step   = CNT_W'(st);
    cycle();
    cfg_bus.cfg_we     = 1'b0;
  endtask

  int exp0[5]  = '{0, 2, 4, 5, 5};
  int exp1[11] = '{0, 8, 8, 8, 8, 8, 5, 2, 1, 1, 7};

  initial begin
    int g, n;
    rst_n = 1'b0; en = 1'b0; per = 16'd9;
    cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_ch = '0;
    cfg_bus.cfg_target = '0; cfg_bus.cfg_step = '0;
    tick_cnt = 0;
    model_reset();
    clear_hist();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1; en = 1'b1;

    // asynchronous reset in the middle of a period
    cfg_write(0, 3, 0);
    wait_ticks(2);
    g = 0;
    while (mcnt != 5 && g < 50) begin cycle(); g++; end
    check("pre_rst_active0", dut.active_reg[0], 3);
    #2 rst_n = 1'b0;
    #1;
    check("rst_pwm", pwm_out, 0);
    check("rst_tick", period_tick, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", dut.cnt_reg, 0);
    check("rst_sweep", sweep_active, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_active0", dut.active_reg[0], 0);

    // ramp up ch0, preset ch1, ch3 above period, ch2 stays at zero
    clear_hist();
    cfg_write(0, 5, 2);
    cfg_write(1, 8, 0);
    cfg_write(3, 12, 0);
    wait_ticks(5);
    repeat (6) cycle();
    cfg_write(1, 1, 3);
    wait_ticks(4);
    repeat (6) cycle();
    cfg_write(1, 7, 0);
    wait_ticks(3);
    check("hist_len", hist1.size(), 11);
    for (int i = 0; i < 5; i++)  check($sformatf("ramp_up_p%0d", i + 1), hist0[i], exp0[i]);
    for (int i = 0; i < 11; i++) check($sformatf("ramp_dn_p%0d", i + 1), hist1[i], exp1[i]);
    check("ch2_low_p1", hist2[0], 0);
    check("ch2_low_p11", hist2[10], 0);
    check("ch3_p1", hist3[0], 0);
    check("ch3_high_p2", hist3[1], 10);
    check("ch3_high_p11", hist3[10], 10);
    check("plen_p1", plen[0], 10);
    check("plen_p11", plen[10], 10);
    check("busy0_settled", busy[0], 0);

    // config write colliding with the sweep slot of ch2
    wait_ticks(1);
    cycle();
    cycle();
    cfg_write(2, 6, 0);
    check("coll_old_dut", dut.shadow_reg[2], 0);
    check("coll_old_model", mshadow[2], 0);
    wait_ticks(1);
    repeat (4) cycle();
    check("coll_new_dut", dut.shadow_reg[2], 6);
    check("coll_new_model", mshadow[2], 6);

    // disable then re-enable
    en = 1'b0;
    repeat (5) cycle();
    check("dis_sweep", sweep_active, 0);
    check("dis_cnt", dut.cnt_reg, 0);
    check("dis_pwm", pwm_out, 0);
    en = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!period_tick && n < 100);
    check("en_first_tick", n, 10);

    // short period: ticks arrive faster than a sweep completes
    per = 16'd1;
    repeat (150) begin
      if ($urandom_range(0, 99) < 30)
        cfg_write($urandom_range(0, NUM_CH - 1), $urandom_range(0, 12), $urandom_range(0, 4));
      else
        cycle();
    end

    // mixed random traffic: period changes, enable toggles, config writes
    repeat (600) begin
      if ($urandom_range(0, 99) < 5) per = CNT_W'($urandom_range(0, 7));
      if (en) begin
        if ($urandom_range(0, 99) < 3) en = 1'b0;
      end else if ($urandom_range(0, 99) < 30) begin
        en = 1'b1;
      end
      if ($urandom_range(0, 99) < 20)
        cfg_write($urandom_range(0, NUM_CH - 1), $urandom_range(0, 12), $urandom_range(0, 4));
      else
        cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
